mult_datapath: RTL and testbench
================================

Name: mult_datapath

Overview:
Shift-add datapath for the 16x9 sequential multiplier, directly downstream of the control ROM. It consumes the six control strobes and holds the multiplicand register (MX), the multiplier shift register (MY) and the partial-product accumulator. It produces the 25-bit product and flags completion once Y_WIDTH add-shift steps have run since the last clear.

Parameters:
X_WIDTH, 16, multiplicand width
Y_WIDTH, 9, multiplier width; PRODUCT width is X_WIDTH+Y_WIDTH

Ports:
CLK  input  1  rising-edge clock
RST  input  1  asynchronous, active-high reset
MX_IN  input  X_WIDTH  multiplicand operand
MY_IN  input  Y_WIDTH  multiplier operand
LOAD_MX  input  1  MX <= MX_IN
LOAD_MY  input  1  MY <= MY_IN
SHIFT_MY  input  1  MY logical shift right by 1
CLEAR_ACC  input  1  accumulator, step counter and OVF cleared
LOAD_ACC  input  1  add (MY[0] ? MX : 0) into accumulator upper field
SHIFT_IN  input  1  shift accumulator right by 1, carry enters MSB
PRODUCT  output  X_WIDTH+Y_WIDTH  product / accumulator view
PRODUCT_VALID  output  1  Y_WIDTH add-shift steps completed
OVF  output  1  sticky: carry dropped by a LOAD_ACC-only add
DONE  output  1  completion pulse (see Optional Feature)

Behaviour:
- One clock, CLK. RST is asynchronous and active-high. Reset clears MX, MY, ACC, CNT, OVF, PRODUCT_VALID, DONE and any shadow register to 0.
- All strobes are sampled at the CLK rising edge. Control strobes arrive one cycle after the ROM state; no internal decode delay is added.
- Let U = ACC[24:9] and ADD = MY[0] ? MX : 0. MY[0] is the value before any same-cycle shift.
- LOAD_ACC && SHIFT_IN (step): ACC <= {U+ADD (17 bits), ACC[8:1]}; CNT <= CNT+1.
- LOAD_ACC only: U <= (U+ADD)[15:0]; OVF <= OVF | carry. CNT is unchanged.
- SHIFT_IN only: ACC <= {1'b0, ACC[24:1]}. CNT is unchanged.
- Priority:
  - CLEAR_ACC overrides LOAD_ACC/SHIFT_IN in the same cycle.
  - LOAD_MY overrides SHIFT_MY.
  - LOAD_MX, LOAD_MY and CLEAR_ACC may all be asserted together (the ROM start state does this).
- CNT is $clog2(Y_WIDTH+1) bits. PRODUCT_VALID = (CNT == Y_WIDTH), registered.
- Once PRODUCT_VALID=1, LOAD_ACC, SHIFT_IN and SHIFT_MY are ignored and ACC/MY/CNT are frozen. This covers ROM overrun.
- PRODUCT_VALID is also cleared by LOAD_MY. LOAD_MX alone is always honoured; it does not affect CNT.
- PRODUCT = ACC, combinational from the register (no extra latency) when the macro is absent.
- Latency: a start cycle followed by 9 step cycles. PRODUCT_VALID rises on the edge that completes step 9.
- Reset mid-operation returns everything to 0 immediately. No partial state survives.

Optional Feature:
Macro PRODUCT_HOLD_EN.
- Defined:
  - A shadow register captures the next-ACC value on the step that makes CNT reach Y_WIDTH.
  - PRODUCT is driven from the shadow register and survives CLEAR_ACC/LOAD_MY until the next completion.
  - DONE is a 1-cycle pulse in the cycle after that capture.
- Undefined: PRODUCT = ACC and DONE is tied 0.

Decomposition:
- Shared package mult_pkg:
  - X_WIDTH, Y_WIDTH, P_WIDTH constants.
  - Control-word bit indices (LOAD_MX=9 … SHIFT_IN=4, NEXTSTATE=3:0).
  - Step-count constant.
- One natural sub-module, mult_acc_shift: the accumulator register, adder and CNT. The top level holds MX/MY and the flags.

Test Plan:
- Start cycle (LOAD_MX, LOAD_MY, CLEAR_ACC with MX_IN=16'h1234, MY_IN=9'h0A5), then 9 step cycles (SHIFT_MY, LOAD_ACC, SHIFT_IN) -> PRODUCT=25'h00BBB84, PRODUCT_VALID=1 exactly after step 9.
- MX_IN=16'hFFFF, MY_IN=9'h1FF, same sequence -> PRODUCT=25'h1FEFE01, OVF=0.
- MY_IN=9'h000 -> PRODUCT=0 and PRODUCT_VALID=1 after 9 steps. Then 3 extra steps -> PRODUCT, CNT and MY are unchanged.
- Assert RST asynchronously after step 4 -> all outputs 0 before the next edge. A new start plus 9 steps with 16'h0003*9'h005 -> 25'h000000F.
- LOAD_ACC only with U=16'hFFFF, MX=16'h0001, MY[0]=1 -> U=16'h0000, OVF=1 and sticky until CLEAR_ACC.
- With PRODUCT_HOLD_EN: complete 16'h1234*9'h0A5, then a new start with CLEAR_ACC -> PRODUCT holds 25'h00BBB84; DONE pulses high for exactly one cycle after the capture.

Source files
------------

// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared constants, control-word bit layout and accumulator
//               operation decode for the 16x9 shift-add multiplier datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

    // Operand and product widths
    localparam int c_X_WIDTH = 16;
    localparam int c_Y_WIDTH = 9;
    localparam int c_P_WIDTH = c_X_WIDTH + c_Y_WIDTH;

    // One add-shift step per multiplier bit
    localparam int c_STEP_COUNT = c_Y_WIDTH;

    // Control ROM word layout: six strobes above a 4-bit next-state field
    localparam int c_CW_LOAD_MX       = 9;
    localparam int c_CW_LOAD_MY       = 8;
    localparam int c_CW_SHIFT_MY      = 7;
    localparam int c_CW_CLEAR_ACC     = 6;
    localparam int c_CW_LOAD_ACC      = 5;
    localparam int c_CW_SHIFT_IN      = 4;
    localparam int c_CW_NEXTSTATE_MSB = 3;
    localparam int c_CW_NEXTSTATE_LSB = 0;
    localparam int c_CW_NEXTSTATE_W   = c_CW_NEXTSTATE_MSB - c_CW_NEXTSTATE_LSB + 1;
    localparam int c_CW_STROBES_LSB   = c_CW_NEXTSTATE_LSB + c_CW_NEXTSTATE_W;

    // Accumulator operation selected by the LOAD_ACC / SHIFT_IN pair
    typedef enum logic [1:0] {
        ACC_HOLD  = 2'b00,
        ACC_SHIFT = 2'b01,
        ACC_ADD   = 2'b10,
        ACC_STEP  = 2'b11
    } acc_op_e;

    function automatic acc_op_e acc_op_decode(input logic load_acc, input logic shift_in);
        case ({load_acc, shift_in})
            2'b11:   return ACC_STEP;
            2'b10:   return ACC_ADD;
            2'b01:   return ACC_SHIFT;
            default: return ACC_HOLD;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_acc_shift.sv
`default_nettype none
// ============================================================================
// Module      : mult_acc_shift
// Description : Partial-product accumulator, its adder and the step counter.
//               A combined add+shift is one multiply step and advances the
//               counter; add-only and shift-only leave the counter alone.
//               With PRODUCT_HOLD_EN defined, a shadow register captures the
//               accumulator value written by the completing step and drives
//               the product output instead of the live accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_acc_shift
    import mult_pkg::*;
#(
    parameter int X_WIDTH = c_X_WIDTH,
    parameter int Y_WIDTH = c_STEP_COUNT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_clear,
    input  logic                       i_freeze,
    input  logic                       i_load_acc,
    input  logic                       i_shift_in,
    input  logic [X_WIDTH-1:0]         i_add_val,
    output logic [X_WIDTH+Y_WIDTH-1:0] o_product,
    output logic                       o_complete,
    output logic                       o_carry_drop
);

    localparam int P_WIDTH = X_WIDTH + Y_WIDTH;
    localparam int CNT_W   = $clog2(Y_WIDTH + 1);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(Y_WIDTH);

    logic [P_WIDTH-1:0] r_acc;
    logic [P_WIDTH-1:0] w_acc_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [X_WIDTH:0]   w_sum;
    acc_op_e            w_op;

    // Once the product is valid every accumulate/shift request is ignored
    assign w_op  = i_freeze ? ACC_HOLD : acc_op_decode(i_load_acc, i_shift_in);

    // Upper field plus the selected multiplicand, keeping the carry bit
    assign w_sum = {1'b0, r_acc[P_WIDTH-1:Y_WIDTH]} + {1'b0, i_add_val};

    // Next accumulator / counter value; clear beats every other operation
    always_comb begin
        w_acc_next   = r_acc;
        w_cnt_next   = r_cnt;
        o_complete   = 1'b0;
        o_carry_drop = 1'b0;
        if (i_clear) begin
            w_acc_next = '0;
            w_cnt_next = '0;
        end else begin
            case (w_op)
                ACC_STEP: begin
                    // The adder carry becomes the new MSB as the field shifts down
                    w_acc_next = {w_sum, r_acc[Y_WIDTH-1:1]};
                    w_cnt_next = r_cnt + 1'b1;
                    o_complete = (w_cnt_next == c_CNT_LAST);
                end
                ACC_ADD: begin
                    // Without a shift there is nowhere to keep the carry
                    w_acc_next   = {w_sum[X_WIDTH-1:0], r_acc[Y_WIDTH-1:0]};
                    o_carry_drop = w_sum[X_WIDTH];
                end
                ACC_SHIFT: begin
                    w_acc_next = {1'b0, r_acc[P_WIDTH-1:1]};
                end
                default: begin
                end
            endcase
        end
    end

    // Accumulator and step counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else begin
            r_acc <= w_acc_next;
            r_cnt <= w_cnt_next;
        end
    end

`ifdef PRODUCT_HOLD_EN
    logic [P_WIDTH-1:0] r_shadow;

    // Shadow copy of the finished product, kept across the next start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= '0;
        end else if (o_complete) begin
            r_shadow <= w_acc_next;
        end
    end

    assign o_product = r_shadow;
`else
    assign o_product = r_acc;
`endif

endmodule
`default_nettype wire

// File: rtl/mult_datapath.sv
`default_nettype none
// ============================================================================
// Module      : mult_datapath
// Description : Shift-add datapath of the 16x9 sequential multiplier. Holds
//               the multiplicand (MX) and multiplier shift register (MY),
//               the completion and overflow flags, and instantiates the
//               accumulator/counter block. Optional macro PRODUCT_HOLD_EN
//               holds the last product in a shadow register and pulses DONE.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_datapath
    import mult_pkg::*;
#(
    parameter int X_WIDTH = c_X_WIDTH,
    parameter int Y_WIDTH = c_Y_WIDTH
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [X_WIDTH-1:0]         MX_IN,
    input  logic [Y_WIDTH-1:0]         MY_IN,
    input  logic                       LOAD_MX,
    input  logic                       LOAD_MY,
    input  logic                       SHIFT_MY,
    input  logic                       CLEAR_ACC,
    input  logic                       LOAD_ACC,
    input  logic                       SHIFT_IN,
    output logic [X_WIDTH+Y_WIDTH-1:0] PRODUCT,
    output logic                       PRODUCT_VALID,
    output logic                       OVF,
    output logic                       DONE
);

    logic [c_CW_LOAD_MX:c_CW_STROBES_LSB] w_cw;
    logic                 w_load_mx;
    logic                 w_load_my;
    logic                 w_shift_my;
    logic                 w_clear_acc;
    logic                 w_load_acc;
    logic                 w_shift_in;
    logic [X_WIDTH-1:0]   r_mx;
    logic [Y_WIDTH-1:0]   r_my;
    logic [X_WIDTH-1:0]   w_add_val;
    logic                 r_valid;
    logic                 r_ovf;
    logic                 w_complete;
    logic                 w_carry_drop;

    // Strobes viewed in their control-word positions
    assign w_cw        = {LOAD_MX, LOAD_MY, SHIFT_MY, CLEAR_ACC, LOAD_ACC, SHIFT_IN};
    assign w_load_mx   = w_cw[c_CW_LOAD_MX];
    assign w_load_my   = w_cw[c_CW_LOAD_MY];
    assign w_shift_my  = w_cw[c_CW_SHIFT_MY];
    assign w_clear_acc = w_cw[c_CW_CLEAR_ACC];
    assign w_load_acc  = w_cw[c_CW_LOAD_ACC];
    assign w_shift_in  = w_cw[c_CW_SHIFT_IN];

    // MY[0] is the pre-shift bit, so a same-cycle SHIFT_MY does not affect it
    assign w_add_val = r_my[0] ? r_mx : '0;

    // Multiplicand register; a load is always honoured
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_mx <= '0;
        end else if (w_load_mx) begin
            r_mx <= MX_IN;
        end
    end

    // Multiplier shift register; load wins over shift, shift frozen when valid
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_my <= '0;
        end else if (w_load_my) begin
            r_my <= MY_IN;
        end else if (w_shift_my && !r_valid) begin
            r_my <= {1'b0, r_my[Y_WIDTH-1:1]};
        end
    end

    // Completion flag set by the final step, dropped by a new clear or MY load
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_valid <= 1'b0;
        end else if (w_clear_acc || w_load_my) begin
            r_valid <= 1'b0;
        end else if (w_complete) begin
            r_valid <= 1'b1;
        end
    end

    // Sticky overflow from add-only operations, cleared with the accumulator
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ovf <= 1'b0;
        end else if (w_clear_acc) begin
            r_ovf <= 1'b0;
        end else if (w_carry_drop) begin
            r_ovf <= 1'b1;
        end
    end

    mult_acc_shift #(
        .X_WIDTH (X_WIDTH),
        .Y_WIDTH (Y_WIDTH)
    ) u_acc_shift (
        .clk          (CLK),
        .rst          (RST),
        .i_clear      (w_clear_acc),
        .i_freeze     (r_valid),
        .i_load_acc   (w_load_acc),
        .i_shift_in   (w_shift_in),
        .i_add_val    (w_add_val),
        .o_product    (PRODUCT),
        .o_complete   (w_complete),
        .o_carry_drop (w_carry_drop)
    );

    assign PRODUCT_VALID = r_valid;
    assign OVF           = r_ovf;

`ifdef PRODUCT_HOLD_EN
    logic r_done;

    // One-cycle pulse in the cycle following the shadow capture
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_complete;
        end
    end

    assign DONE = r_done;
`else
    assign DONE = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mult_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_datapath
// Description : Scoreboard bench for mult_datapath: directed sequences plus
//               randomized multiplies checked against plain multiplication.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_datapath;

`ifdef PRODUCT_HOLD_EN
    localparam bit c_HOLD = 1'b1;
`else
    localparam bit c_HOLD = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] MX_IN = '0;
    logic [8:0]  MY_IN = '0;
    logic        LOAD_MX = 1'b0, LOAD_MY = 1'b0, SHIFT_MY = 1'b0;
    logic        CLEAR_ACC = 1'b0, LOAD_ACC = 1'b0, SHIFT_IN = 1'b0;
    logic [24:0] PRODUCT;
    logic        PRODUCT_VALID, OVF, DONE;

    mult_datapath dut (
        .CLK(CLK), .RST(RST), .MX_IN(MX_IN), .MY_IN(MY_IN),
        .LOAD_MX(LOAD_MX), .LOAD_MY(LOAD_MY), .SHIFT_MY(SHIFT_MY),
        .CLEAR_ACC(CLEAR_ACC), .LOAD_ACC(LOAD_ACC), .SHIFT_IN(SHIFT_IN),
        .PRODUCT(PRODUCT), .PRODUCT_VALID(PRODUCT_VALID), .OVF(OVF), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [24:0] prod;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          failures = 0;
    logic [24:0] last_result = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_strobes(input logic lmx, input logic lmy, input logic smy,
                               input logic clr, input logic lacc, input logic sin);
        LOAD_MX = lmx; LOAD_MY = lmy; SHIFT_MY = smy;
        CLEAR_ACC = clr; LOAD_ACC = lacc; SHIFT_IN = sin;
    endtask

    task automatic drive(input logic lmx, input logic lmy, input logic smy,
                         input logic clr, input logic lacc, input logic sin);
        @(negedge CLK);
        set_strobes(lmx, lmy, smy, clr, lacc, sin);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK);
            set_strobes(0, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic start(input logic [15:0] x, input logic [8:0] y);
        @(negedge CLK);
        MX_IN = x;
        MY_IN = y;
        set_strobes(1, 1, 0, 1, 0, 0);
    endtask

    // Issue one step; the last one registers the expected product and the
    // edge number on which PRODUCT_VALID must appear
    task automatic step(input bit last, input logic [24:0] e);
        @(negedge CLK);
        set_strobes(0, 0, 1, 0, 1, 1);
        if (last) sb.push_back('{prod: e, cyc: cyc + 1});
    endtask

    task automatic multiply(input logic [15:0] x, input logic [8:0] y, input bit gaps);
        logic [24:0] e;
        e = 25'(x) * 25'(y);
        start(x, y);
        @(negedge CLK);
        set_strobes(0, 0, 0, 0, 0, 0);
        check("start_valid", 32'(PRODUCT_VALID), 32'd0);
        check("start_product", 32'(PRODUCT), c_HOLD ? 32'(last_result) : 32'd0);
        for (int i = 0; i < 9; i++) begin
            if (gaps) idle($urandom_range(0, 2));
            step(i == 8, e);
        end
        idle(1);
        last_result = e;
    endtask

    // Monitor: on every rising PRODUCT_VALID pop and compare the scoreboard
    logic prev_valid = 1'b0;
    bit   prev_rise = 1'b0;
    always @(negedge CLK) begin : monitor
        bit rise;
        rise = PRODUCT_VALID && !prev_valid;
        if (rise) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid actual=1 expected=0 (t=%0t)", $time);
            end else begin
                mon_e = sb.pop_front();
                check("product", 32'(PRODUCT), 32'(mon_e.prod));
                check("valid_latency", 32'(cyc), 32'(mon_e.cyc));
            end
            check("done_on_capture", 32'(DONE), 32'(c_HOLD));
        end else if (prev_rise) begin
            check("done_one_cycle", 32'(DONE), 32'd0);
        end
        prev_rise  = rise;
        prev_valid = PRODUCT_VALID;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin : stim
        logic [15:0] rx;
        logic [8:0]  ry;

        // Reset state
        idle(2);
        check("rst_product", 32'(PRODUCT), 32'd0);
        check("rst_valid", 32'(PRODUCT_VALID), 32'd0);
        check("rst_ovf", 32'(OVF), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        RST = 1'b0;

        // 0x1234 * 0x0A5, then ROM overrun must leave everything frozen
        multiply(16'h1234, 9'h0A5, 1'b0);
        check("t1_valid", 32'(PRODUCT_VALID), 32'd1);
        for (int i = 0; i < 3; i++) step(1'b0, '0);
        drive(0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 1);
        idle(1);
        check("overrun_product", 32'(PRODUCT), 32'h00BBB84);
        check("overrun_valid", 32'(PRODUCT_VALID), 32'd1);
        check("overrun_ovf", 32'(OVF), 32'd0);

        // Largest operands
        multiply(16'hFFFF, 9'h1FF, 1'b0);
        check("max_product", 32'(PRODUCT), 32'h1FEFE01);
        check("max_ovf", 32'(OVF), 32'd0);

        // Zero multiplier and overrun
        multiply(16'h1234, 9'h000, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0);
        idle(1);
        check("zero_product", 32'(PRODUCT), 32'd0);
        check("zero_valid", 32'(PRODUCT_VALID), 32'd1);

        // Asynchronous reset after step 4
        start(16'h1234, 9'h0A5);
        for (int i = 0; i < 4; i++) step(1'b0, '0);
        idle(1);
        #2 RST = 1'b1;
        #1;
        check("async_rst_product", 32'(PRODUCT), 32'd0);
        check("async_rst_valid", 32'(PRODUCT_VALID), 32'd0);
        check("async_rst_ovf", 32'(OVF), 32'd0);
        check("async_rst_done", 32'(DONE), 32'd0);
        #1 RST = 1'b0;
        last_result = '0;
        multiply(16'h0003, 9'h005, 1'b0);
        check("post_rst_product", 32'(PRODUCT), 32'h000000F);

        // Add-only overflow: U=FFFF + MX=1 drops the carry, OVF sticks
        start(16'hFFFF, 9'h001);
        drive(0, 0, 0, 0, 1, 0);
        @(negedge CLK);
        if (!c_HOLD) check("add_only_product", 32'(PRODUCT), 32'h1FFFE00);
        check("add_only_ovf0", 32'(OVF), 32'd0);
        MX_IN = 16'h0001;
        set_strobes(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0);
        idle(1);
        if (!c_HOLD) check("wrap_product", 32'(PRODUCT), 32'd0);
        check("ovf_set", 32'(OVF), 32'd1);
        check("wrap_valid", 32'(PRODUCT_VALID), 32'd0);
        idle(2);
        check("ovf_sticky", 32'(OVF), 32'd1);
        drive(0, 0, 0, 1, 0, 0);
        idle(1);
        check("ovf_cleared", 32'(OVF), 32'd0);

        // Shift-only moves the whole accumulator right by one
        start(16'hFFFF, 9'h001);
        drive(0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 1);
        idle(1);
        if (!c_HOLD) check("shift_only_product", 32'(PRODUCT), 32'h0FFFF00);
        check("shift_only_valid", 32'(PRODUCT_VALID), 32'd0);

        // Product held (hold build) or cleared (default) across a new start
        multiply(16'h1234, 9'h0A5, 1'b0);
        start(16'h0007, 9'h003);
        idle(1);
        check("restart_product", 32'(PRODUCT), c_HOLD ? 32'h00BBB84 : 32'd0);
        check("restart_valid", 32'(PRODUCT_VALID), 32'd0);

        // Randomized multiplies with random gaps and occasional overrun
        for (int n = 0; n < 25; n++) begin
            rx = 16'($urandom);
            ry = 9'($urandom_range(0, 511));
            multiply(rx, ry, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                step(1'b0, '0);
                idle(1);
                check("rand_overrun", 32'(PRODUCT), 32'(25'(rx) * 25'(ry)));
            end
        end

        idle(3);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
